// File: rtl/regfile_seq.sv
// regfile_seq: micro-sequencer for an 8x4-bit register file with two
// combinational read ports (P/Q) and one synchronous write port.
// It accepts one register-to-register instruction per valid/ready handshake.
// Each instruction then runs READ -> EXEC -> WRITE. Retirement gives a
// one-cycle DONE pulse, and FLAG_C/FLAG_Z update after the write.
//
// Ports
//   CLK, CLRN                      clock, synchronous active-low reset
//   IN_VALID/IN_READY              instruction handshake
//   IN_OP/IN_DST/IN_SRCA/IN_SRCB   instruction fields (opcode, registers)
//   IN_IMM                         immediate for LDI
//   RP/RQ, DATAP/DATAQ             register file read ports
//   WA/WR/LD_DATA                  register file write port
//   DONE, FLAG_C, FLAG_Z           retirement pulse and status flags
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | ready; latch the instruction on IN_VALID
// S_READ  | RP/RQ present sources; capture DATAP/DATAQ into opA/opB
// S_EXEC  | compute result and pending flags into registers
// S_WRITE | drive write port, pulse DONE, commit flags at the edge

module regfile_seq #(
  parameter int WIDTH = 4,
  parameter int AW    = 3
) (
  input  logic             CLK,
  input  logic             CLRN,
  input  logic             IN_VALID,
  output logic             IN_READY,
  input  logic [2:0]       IN_OP,
  input  logic [AW-1:0]    IN_DST,
  input  logic [AW-1:0]    IN_SRCA,
  input  logic [AW-1:0]    IN_SRCB,
  input  logic [WIDTH-1:0] IN_IMM,
  output logic [AW-1:0]    RP,
  output logic [AW-1:0]    RQ,
  input  logic [WIDTH-1:0] DATAP,
  input  logic [WIDTH-1:0] DATAQ,
  output logic [AW-1:0]    WA,
  output logic             WR,
  output logic [WIDTH-1:0] LD_DATA,
  output logic             DONE,
  output logic             FLAG_C,
  output logic             FLAG_Z
);

  localparam logic [2:0] OP_NOP = 3'b000;
  localparam logic [2:0] OP_MOV = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_SUB = 3'b011;
  localparam logic [2:0] OP_AND = 3'b100;
  localparam logic [2:0] OP_OR  = 3'b101;
  localparam logic [2:0] OP_XOR = 3'b110;
  localparam logic [2:0] OP_LDI = 3'b111;

  typedef enum logic [1:0] {S_IDLE, S_READ, S_EXEC, S_WRITE} state_t;

  state_t           state_q, state_d;
  logic [2:0]       op_q, op_d;
  logic [AW-1:0]    dst_q, dst_d;
  logic [AW-1:0]    srca_q, srca_d;
  logic [AW-1:0]    srcb_q, srcb_d;
  logic [WIDTH-1:0] imm_q, imm_d;
  logic [WIDTH-1:0] opa_q, opa_d;
  logic [WIDTH-1:0] opb_q, opb_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             pend_c_q, pend_c_d;
  logic             pend_z_q, pend_z_d;
  logic             flag_c_q, flag_c_d;
  logic             flag_z_q, flag_z_d;
  logic [WIDTH:0]   wide;

  // State register plus all datapath flops.
  always_ff @(posedge CLK) begin
    if (!CLRN) begin
      state_q  <= S_IDLE;
      op_q     <= '0;
      dst_q    <= '0;
      srca_q   <= '0;
      srcb_q   <= '0;
      imm_q    <= '0;
      opa_q    <= '0;
      opb_q    <= '0;
      res_q    <= '0;
      pend_c_q <= 1'b0;
      pend_z_q <= 1'b0;
      flag_c_q <= 1'b0;
      flag_z_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      dst_q    <= dst_d;
      srca_q   <= srca_d;
      srcb_q   <= srcb_d;
      imm_q    <= imm_d;
      opa_q    <= opa_d;
      opb_q    <= opb_d;
      res_q    <= res_d;
      pend_c_q <= pend_c_d;
      pend_z_q <= pend_z_d;
      flag_c_q <= flag_c_d;
      flag_z_q <= flag_z_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (IN_VALID) state_d = S_READ;
      S_READ:  state_d = S_EXEC;
      S_EXEC:  state_d = S_WRITE;
      S_WRITE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath next values.
  always_comb begin
    op_d     = op_q;
    dst_d    = dst_q;
    srca_d   = srca_q;
    srcb_d   = srcb_q;
    imm_d    = imm_q;
    opa_d    = opa_q;
    opb_d    = opb_q;
    res_d    = res_q;
    pend_c_d = pend_c_q;
    pend_z_d = pend_z_q;
    flag_c_d = flag_c_q;
    flag_z_d = flag_z_q;
    wide     = '0;
    unique case (state_q)
      S_IDLE: begin
        if (IN_VALID) begin
          op_d   = IN_OP;
          dst_d  = IN_DST;
          srca_d = IN_SRCA;
          srcb_d = IN_SRCB;
          imm_d  = IN_IMM;
        end
      end
      S_READ: begin
        opa_d = DATAP;
        opb_d = DATAQ;
      end
      S_EXEC: begin
        pend_c_d = 1'b0;
        unique case (op_q)
          OP_MOV: res_d = opa_q;
          OP_ADD: begin
            wide     = {1'b0, opa_q} + {1'b0, opb_q};
            res_d    = wide[WIDTH-1:0];
            pend_c_d = wide[WIDTH];
          end
          OP_SUB: begin
            // The top bit of the widened difference is the borrow.
            // Carry means "no borrow", i.e. A >= B.
            wide     = {1'b0, opa_q} - {1'b0, opb_q};
            res_d    = wide[WIDTH-1:0];
            pend_c_d = ~wide[WIDTH];
          end
          OP_AND:  res_d = opa_q & opb_q;
          OP_OR:   res_d = opa_q | opb_q;
          OP_XOR:  res_d = opa_q ^ opb_q;
          OP_LDI:  res_d = imm_q;
          default: res_d = res_q;
        endcase
        pend_z_d = (res_d == '0);
      end
      S_WRITE: begin
        if (op_q != OP_NOP) begin
          flag_c_d = pend_c_q;
          flag_z_d = pend_z_q;
        end
      end
      default: ;
    endcase
  end

  // Outputs are decoded from the state or taken straight from flops.
  // RP/RQ/WA follow the latched fields. Those fields only change on
  // accept, so the addresses hold their last values outside READ/WRITE.
  always_comb begin
    IN_READY = (state_q == S_IDLE);
    DONE     = (state_q == S_WRITE);
    WR       = (state_q == S_WRITE) && (op_q != OP_NOP);
    RP       = srca_q;
    RQ       = srcb_q;
    WA       = dst_q;
    LD_DATA  = res_q;
    FLAG_C   = flag_c_q;
    FLAG_Z   = flag_z_q;
  end

endmodule

// File: tb/tb_regfile_seq.sv
module tb_regfile_seq;

  logic       CLK = 1'b0;
  logic       CLRN;
  logic       IN_VALID;
  logic       IN_READY;
  logic [2:0] IN_OP;
  logic [2:0] IN_DST, IN_SRCA, IN_SRCB;
  logic [3:0] IN_IMM;
  logic [2:0] RP, RQ, WA;
  logic [3:0] DATAP, DATAQ, LD_DATA;
  logic       WR, DONE, FLAG_C, FLAG_Z;

  logic [3:0] rf [8];
  int n_tot = 0;
  int n_bad = 0;

  always #5 CLK = ~CLK;

  // Bench-side register file driven by the DUT's write port.
  always @(posedge CLK) if (WR) rf[WA] <= LD_DATA;
  assign DATAP = rf[RP];
  assign DATAQ = rf[RQ];

  regfile_seq #(.WIDTH(4), .AW(3)) dut (
    .CLK(CLK), .CLRN(CLRN),
    .IN_VALID(IN_VALID), .IN_READY(IN_READY),
    .IN_OP(IN_OP), .IN_DST(IN_DST), .IN_SRCA(IN_SRCA), .IN_SRCB(IN_SRCB),
    .IN_IMM(IN_IMM),
    .RP(RP), .RQ(RQ), .DATAP(DATAP), .DATAQ(DATAQ),
    .WA(WA), .WR(WR), .LD_DATA(LD_DATA),
    .DONE(DONE), .FLAG_C(FLAG_C), .FLAG_Z(FLAG_Z)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tot++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d want %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  // Issue one instruction from IDLE and walk it through to retirement.
  task automatic issue(input string nm, input logic [2:0] op, input logic [2:0] d,
                       input logic [2:0] a, input logic [2:0] b, input logic [3:0] imm,
                       input logic [3:0] exp_d, input logic exp_c, input logic exp_z);
    chk({nm, ".ready"}, IN_READY, 1);
    IN_VALID = 1'b1; IN_OP = op; IN_DST = d; IN_SRCA = a; IN_SRCB = b; IN_IMM = imm;
    step();
    IN_VALID = 1'b0;
    chk({nm, ".rd_ready"}, IN_READY, 0);
    chk({nm, ".rp"}, RP, a);
    chk({nm, ".rq"}, RQ, b);
    step();
    chk({nm, ".ex_wr"}, WR, 0);
    chk({nm, ".ex_done"}, DONE, 0);
    step();
    chk({nm, ".done"}, DONE, 1);
    chk({nm, ".wr"}, WR, (op != 3'b000));
    if (op != 3'b000) begin
      chk({nm, ".wa"}, WA, d);
      chk({nm, ".data"}, LD_DATA, exp_d);
    end
    step();
    chk({nm, ".idle_done"}, DONE, 0);
    chk({nm, ".idle_wr"}, WR, 0);
    chk({nm, ".c"}, FLAG_C, exp_c);
    chk({nm, ".z"}, FLAG_Z, exp_z);
    chk({nm, ".rf"}, rf[d], (op != 3'b000) ? exp_d : rf[d]);
  endtask

  // Back-to-back stream vectors: op, dst, srca, srcb, imm, expected data.
  logic [2:0] s_op [5] = '{3'b111, 3'b010, 3'b101, 3'b100, 3'b011};
  logic [2:0] s_d  [5] = '{3'd0, 3'd6, 3'd7, 3'd2, 3'd1};
  logic [2:0] s_a  [5] = '{3'd0, 3'd0, 3'd6, 3'd7, 3'd2};
  logic [2:0] s_b  [5] = '{3'd0, 3'd0, 3'd3, 3'd5, 3'd0};
  logic [3:0] s_im [5] = '{4'd1, 4'd0, 4'd0, 4'd0, 4'd0};
  logic [3:0] s_ex [5] = '{4'd1, 4'd2, 4'd11, 4'd3, 4'd2};

  initial begin
    int idx, n_wr, n_rdy;
    for (int i = 0; i < 8; i++) rf[i] = 4'd0;
    CLRN = 1'b0; IN_VALID = 1'b0; IN_OP = '0; IN_DST = '0;
    IN_SRCA = '0; IN_SRCB = '0; IN_IMM = '0;
    step();
    step();
    chk("rst.ready", IN_READY, 1);
    chk("rst.wr", WR, 0);
    chk("rst.done", DONE, 0);
    chk("rst.rp", RP, 0);
    chk("rst.rq", RQ, 0);
    chk("rst.wa", WA, 0);
    chk("rst.data", LD_DATA, 0);
    chk("rst.c", FLAG_C, 0);
    chk("rst.z", FLAG_Z, 0);
    CLRN = 1'b1;
    step();

    issue("ldi3", 3'b111, 3'd3, 3'd0, 3'd0, 4'd9, 4'd9, 0, 0);
    issue("ldi5", 3'b111, 3'd5, 3'd0, 3'd0, 4'd7, 4'd7, 0, 0);
    issue("add1", 3'b010, 3'd1, 3'd3, 3'd5, 4'd0, 4'd0, 1, 1);
    issue("sub2", 3'b011, 3'd2, 3'd5, 3'd3, 4'd0, 4'd14, 0, 0);

    // IN_VALID held high: each accept loads the next vector.
    idx = 0; n_wr = 0; n_rdy = 0;
    IN_VALID = 1'b1;
    for (int t = 0; t < 20; t++) begin
      if (IN_READY) begin
        n_rdy++;
        if (idx < 5) begin
          IN_OP = s_op[idx]; IN_DST = s_d[idx]; IN_SRCA = s_a[idx];
          IN_SRCB = s_b[idx]; IN_IMM = s_im[idx];
          idx++;
        end
      end
      if (WR) begin
        if (n_wr < 5) begin
          chk("strm.cyc", t, 3 + 4 * n_wr);
          chk("strm.wa", WA, s_d[n_wr]);
          chk("strm.data", LD_DATA, s_ex[n_wr]);
        end
        n_wr++;
      end
      step();
    end
    IN_VALID = 1'b0;
    chk("strm.nwr", n_wr, 5);
    chk("strm.nrdy", n_rdy, 5);
    chk("strm.c", FLAG_C, 1);
    chk("strm.z", FLAG_Z, 0);
    step();

    issue("ldi4", 3'b111, 3'd4, 3'd0, 3'd0, 4'd6, 4'd6, 0, 0);
    issue("xor4", 3'b110, 3'd4, 3'd4, 3'd4, 4'd0, 4'd0, 0, 1);
    issue("mov6", 3'b001, 3'd6, 3'd4, 3'd0, 4'd0, 4'd0, 0, 1);
    issue("addc", 3'b010, 3'd1, 3'd3, 3'd5, 4'd0, 4'd0, 1, 1);
    issue("nop",  3'b000, 3'd5, 3'd0, 3'd0, 4'd0, 4'd0, 1, 1);

    // Abort ADD r7,r3,r5 with reset during EXEC.
    IN_VALID = 1'b1; IN_OP = 3'b010; IN_DST = 3'd7; IN_SRCA = 3'd3; IN_SRCB = 3'd5;
    step();
    IN_VALID = 1'b0;
    step();
    chk("abt.exec_ready", IN_READY, 0);
    CLRN = 1'b0;
    step();
    CLRN = 1'b1;
    chk("abt.wr", WR, 0);
    chk("abt.done", DONE, 0);
    chk("abt.ready", IN_READY, 1);
    chk("abt.c", FLAG_C, 0);
    chk("abt.z", FLAG_Z, 0);
    for (int t = 0; t < 3; t++) begin
      chk("abt.quiet_wr", WR, 0);
      chk("abt.quiet_done", DONE, 0);
      step();
    end
    chk("abt.r7", rf[7], 11);
    issue("post", 3'b111, 3'd7, 3'd0, 3'd0, 4'd5, 4'd5, 0, 0);

    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end

endmodule

// File: doc/regfile_seq.md
Name: regfile_seq

Overview:
Micro-sequencer that drives the 8x4-bit register file (two combinational read ports P/Q, one synchronous write port). It accepts one register-to-register instruction per valid/ready handshake, then sequences READ -> EXEC -> WRITE. It returns a completion pulse plus carry/zero flags. It is the sole driver of the register file address, write-enable and write-data pins.

Parameters:
WIDTH, 4, data width of register file entries and ALU
AW, 3, register address width (2**AW registers)

Ports:
CLK  in  1  clock; all state updates on rising edge
CLRN  in  1  synchronous active-low reset, sampled on CLK rising edge
IN_VALID  in  1  instruction present
IN_READY  out  1  sequencer can accept instruction
IN_OP  in  3  opcode: 000 NOP, 001 MOV, 010 ADD, 011 SUB, 100 AND, 101 OR, 110 XOR, 111 LDI
IN_DST  in  AW  destination register
IN_SRCA  in  AW  source A register (read via port P)
IN_SRCB  in  AW  source B register (read via port Q)
IN_IMM  in  WIDTH  immediate for LDI
RP  out  AW  register file read address P
RQ  out  AW  register file read address Q
DATAP  in  WIDTH  register file read data P (combinational from RP)
DATAQ  in  WIDTH  register file read data Q (combinational from RQ)
WA  out  AW  register file write address
WR  out  1  register file write enable
LD_DATA  out  WIDTH  register file write data
DONE  out  1  one-cycle pulse, instruction retired
FLAG_C  out  1  carry flag
FLAG_Z  out  1  zero flag

Behaviour:
- States: IDLE, READ, EXEC, WRITE. All outputs are registered or decoded from state only; no combinational path from IN_* to outputs except IN_READY = (state==IDLE).
- Reset (CLRN=0 at an edge): state=IDLE, latched instruction fields=0, opA/opB/result=0, FLAG_C=0, FLAG_Z=0. In the cycle after reset: WR=0, DONE=0, RP=RQ=WA=0, LD_DATA=0.
- Reset mid-operation aborts immediately. No write is issued, DONE is not pulsed and the instruction is lost.
- IDLE: IN_READY=1. On an edge with IN_VALID=1, latch OP/DST/SRCA/SRCB/IMM and go to READ. With IN_VALID=0, stay in IDLE.
- READ: RP=SRCA, RQ=SRCB. At the edge, capture DATAP->opA and DATAQ->opB, then go to EXEC. RP/RQ hold their last values outside READ.
- EXEC: compute the registered result and next flags, then go to WRITE.
  - MOV: A.
  - ADD: {C,R}=A+B.
  - SUB: R=A-B mod 2**WIDTH, C=1 iff A>=B unsigned (no borrow).
  - AND/OR/XOR: bitwise, C=0.
  - LDI: R=IMM, C=0.
  - Z=(R==0) for every op except NOP.
- WRITE: WA=DST, LD_DATA=result, WR=1 for exactly this cycle. For NOP, WR=0. DONE=1 for this cycle for all ops. FLAG_C/FLAG_Z update at the end of WRITE (visible the cycle after DONE). NOP leaves the flags unchanged. Go to IDLE.
- Latency: instruction accepted at edge k; write takes effect at edge k+3; DONE high in cycle k+2..k+3; next accept at earliest edge k+4. Throughput is 1 instruction per 4 cycles.
- Hazards: none, because the write completes before the next READ. DST==SRCA or DST==SRCB is legal and reads the old value.
- All WIDTH arithmetic wraps modulo 2**WIDTH; the carry-out goes only to FLAG_C.
- IN_* are ignored outside IDLE. The requester must hold them stable only on the accepting edge.

Test Plan:
- Reset then LDI r3,#9; LDI r5,#7 -> WR pulses with WA=3 LD_DATA=9, then WA=5 LD_DATA=7; each DONE 3 cycles after accept; FLAG_C=0, FLAG_Z=0.
- ADD r1,r3,r5 (9+7) -> WA=1 LD_DATA=0, FLAG_C=1, FLAG_Z=1. Then SUB r2,r5,r3 (7-9) -> LD_DATA=14, FLAG_C=0, FLAG_Z=0.
- IN_VALID held high continuously with 5 different ops -> IN_READY high only 1 cycle in 4; exactly 5 WR pulses spaced 4 cycles apart.
- Self-overwrite: LDI r4,#6 then XOR r4,r4,r4 -> LD_DATA=0 to WA=4, FLAG_Z=1. Then MOV r6,r4 -> LD_DATA=0.
- NOP with flags C=1,Z=1 -> DONE pulses, WR stays 0, flags unchanged.
- CLRN driven low during EXEC of ADD r7,r3,r5 -> no WR pulse, no DONE; next cycle IN_READY=1, FLAG_C=FLAG_Z=0.
